reuse_sel_sched: RTL and testbench
==================================

# reuse_sel_sched

Scheduler that sequences a synchronous-read buffer RAM and the wide select mux behind it. A run covers a set of consecutive RAM rows. For each row, the scheduler fetches the row once, then walks the mux select through every requested entry while the row data stays stable. Every select step is presented downstream on a valid/ready handshake. It sits between the stage controller (start/parameters) and the mux-reuse datapath stage (RAM address, mux select).

## Interface
- ADDR_WIDTH, 4, RAM address width; RAM depth = 1 << ADDR_WIDTH
- SEL_WIDTH, 7, mux select width
- NUM_INPUTS, 81, number of legal mux inputs; select range 0..NUM_INPUTS-1
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous and active-low
- i_start  in  1  start request; sampled only in IDLE
- i_base_addr  in  ADDR_WIDTH  first RAM row of the run
- i_num_rows  in  ADDR_WIDTH+1  rows in the run, 1..1<<ADDR_WIDTH
- i_num_sel  in  SEL_WIDTH+1  selects per row, 1..NUM_INPUTS
- i_abort  in  1  synchronous abort of a run in progress
- i_ready  in  1  downstream accepts the current select
- o_ram_addr  out  ADDR_WIDTH  RAM address, held stable while a row streams
- o_sel  out  SEL_WIDTH  mux select
- o_valid  out  1  o_sel valid; RAM data for the row is valid
- o_row_last  out  1  current select is the last one of its row
- o_last  out  1  current select is the last one of the run
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse when a run completes
- o_err  out  1  one-cycle pulse when a start is rejected (see Configuration)

## Operation
- States:
  - IDLE: waits for a start.
  - FETCH: drives the row address; RAM latches it at the end of this cycle.
  - STREAM: o_valid=1 and walks the select.
  - DONE: one cycle, with o_done=1.
- Transitions:
  - IDLE -> FETCH on i_start. Latches the parameters and sets o_ram_addr=i_base_addr, row counter=0, o_sel=0.
  - FETCH -> STREAM unconditionally.
  - STREAM, on handshake (o_valid & i_ready):
    - if o_sel < num_sel-1: o_sel+1, stay in STREAM.
    - else, if not the last row: o_sel=0, o_ram_addr+1, row counter+1, go to FETCH.
    - else: go to DONE.
  - DONE -> IDLE.
- No handshake: o_sel, o_ram_addr and o_valid are held.
- o_ram_addr wraps modulo 1<<ADDR_WIDTH.
- Flag outputs:
  - o_row_last = o_valid & (o_sel == num_sel-1).
  - o_last = o_row_last & (row counter == num_rows-1).
- Latched parameters are immune to input changes during a run.
- i_start while busy is ignored.
- i_abort in FETCH or STREAM:
  - goes to IDLE at the next edge.
  - no o_done.
  - o_valid drops the next cycle.
  - i_abort has priority over a simultaneous handshake.
- Reset mid-run: asynchronous return to IDLE, and all outputs take their reset values immediately.

## Timing
- Reset values:
  - state IDLE.
  - o_ram_addr=0, o_sel=0.
  - o_valid, o_row_last, o_last, o_busy, o_done and o_err all 0.
- Start latency: i_start sampled at edge E0. FETCH runs in cycle E0..E1. o_valid=1 with o_sel=0 from E1.
- Throughput: one select per cycle when i_ready=1. Each row boundary costs exactly one bubble cycle (FETCH).
- Full-ready run length: num_rows*(num_sel+1)+1 cycles from the start edge to the o_done cycle inclusive.
- All outputs are registered; there is no combinational path from i_ready to o_valid.

## Configuration
- SCHED_PARAM_CHECK_EN defined:
  - rejects a start if i_num_sel==0, i_num_sel>NUM_INPUTS or i_num_rows==0.
  - On reject: stays in IDLE and pulses o_err for one cycle at the edge after the start.
- Not defined:
  - no check; o_err is tied to 0.
  - Out-of-range values are run as given; mux output for illegal selects is undefined.
  - num_sel==0 or num_rows==0 is undefined usage.

## Structure
- Package reuse_sched_pkg holds:
  - the state encoding (IDLE, FETCH, STREAM, DONE).
  - default width constants.
- Sub-module sel_step_counter: a loadable up-counter with a terminal-count flag. It has two instances, one for the select and one for the row.
- The FSM and handshake logic sit in reuse_sel_sched.

## Test plan
- Base rows, always ready: base=3, rows=2, sel=4, i_ready=1 → sequence below; o_done pulses at cycle 11.
  - address 3 with selects 0,1,2,3, one bubble, then address 4 with selects 0..3.
  - o_row_last on each select 3; o_last only on the second one.
- Backpressure: i_ready low for 3 cycles at sel=2 → o_sel=2 and o_ram_addr held; no select skipped or duplicated.
- Wrap-around: base=15, rows=2, ADDR_WIDTH=4 → second row address is 0.
- Abort: i_abort during STREAM with i_ready=1 → IDLE next edge; o_valid=0; no o_done; a new start runs normally.
- Async reset: i_rst_n low mid-STREAM, not on a clock edge → all outputs 0 immediately; start after release behaves as after power-up.
- Parameter check with the macro defined: start with sel=82 → o_err pulse; o_busy stays 0. Without the macro, o_err stays 0.

Source files
------------

// File: rtl/reuse_sched_pkg.sv
// Shared definitions for the select/row scheduler: state encoding and
// default width constants used by reuse_sel_sched and its counters.
package reuse_sched_pkg;

    // Default build widths; the top exposes these as overridable parameters.
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_SEL_WIDTH  = 7;
    localparam int DEF_NUM_INPUTS = 81;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sel_step_counter.sv
// Loadable up-counter with a terminal-count flag.
// A load captures both the start value and the terminal value, so the
// terminal is frozen for the whole run. Stepping while at the terminal
// value wraps the count back to zero (used to restart the select at a row
// boundary). The visible count may be narrower than the internal one.
module sel_step_counter #(
    parameter int W     = 8,
    parameter int OUT_W = W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     first,
    input  logic [W-1:0]     last,
    input  logic             step,
    output logic [OUT_W-1:0] count,
    output logic             at_last
);

    logic [W-1:0] count_reg;
    logic [W-1:0] last_reg;

    // Count register: load wins over step; step at terminal wraps to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            last_reg  <= '0;
        end else if (load) begin
            count_reg <= first;
            last_reg  <= last;
        end else if (step) begin
            if (count_reg == last_reg) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + W'(1);
            end
        end
    end

    assign count   = count_reg[OUT_W-1:0];
    assign at_last = (count_reg == last_reg);

endmodule

// File: rtl/reuse_sel_sched.sv
// Row-fetch / select-walk scheduler for a synchronous-read buffer RAM
// feeding a wide select mux. Each row is fetched once (one bubble cycle),
// then every requested select is offered on a valid/ready handshake while
// the row address stays put.
// Optional start-parameter checking is enabled by defining
// SCHED_PARAM_CHECK_EN; without it o_err is tied low.
module reuse_sel_sched
    import reuse_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_num_rows,
    input  logic [SEL_WIDTH:0]    i_num_sel,
    input  logic                  i_abort,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [SEL_WIDTH-1:0]  o_sel,
    output logic                  o_valid,
    output logic                  o_row_last,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    // The row counter runs one bit wider than the address and counts
    // absolute row addresses from base to base+rows-1; its low bits are the
    // RAM address, so wrap-around of the address falls out for free while
    // the terminal compare still sees the unwrapped value.
    localparam int SW = SEL_WIDTH + 1;
    localparam int AW = ADDR_WIDTH + 1;

    sched_state_t state_reg;
    sched_state_t state_next;

    logic          start_load;
    logic          sel_step;
    logic          row_step;
    logic          sel_at_last;
    logic          row_at_last;
    logic [SW-1:0] sel_last_in;
    logic [AW-1:0] row_first_in;
    logic [AW-1:0] row_last_in;

    assign sel_last_in  = i_num_sel - SW'(1);
    assign row_first_in = {1'b0, i_base_addr};
    assign row_last_in  = row_first_in + i_num_rows - AW'(1);

`ifdef SCHED_PARAM_CHECK_EN
    logic params_ok;
    logic err_next;
    logic err_reg;

    assign params_ok = (i_num_sel != '0) &&
                       (i_num_sel <= SW'(NUM_INPUTS)) &&
                       (i_num_rows != '0);
`endif

    // Select counter: restarts at zero on every row, terminal num_sel-1.
    sel_step_counter #(
        .W     (SW),
        .OUT_W (SEL_WIDTH)
    ) u_sel_cnt (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .load    (start_load),
        .first   ('0),
        .last    (sel_last_in),
        .step    (sel_step),
        .count   (o_sel),
        .at_last (sel_at_last)
    );

    // Row counter: holds the current row address, terminal is the last row.
    sel_step_counter #(
        .W     (AW),
        .OUT_W (ADDR_WIDTH)
    ) u_row_cnt (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .load    (start_load),
        .first   (row_first_in),
        .last    (row_last_in),
        .step    (row_step),
        .count   (o_ram_addr),
        .at_last (row_at_last)
    );

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and counter control; abort outranks a same-cycle handshake.
    always_comb begin
        state_next = state_reg;
        start_load = 1'b0;
        sel_step   = 1'b0;
        row_step   = 1'b0;
`ifdef SCHED_PARAM_CHECK_EN
        err_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (i_start) begin
`ifdef SCHED_PARAM_CHECK_EN
                    if (params_ok) begin
                        start_load = 1'b1;
                        state_next = FETCH;
                    end else begin
                        err_next = 1'b1;
                    end
`else
                    start_load = 1'b1;
                    state_next = FETCH;
`endif
                end
            end
            FETCH: begin
                state_next = i_abort ? IDLE : STREAM;
            end
            STREAM: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (i_ready) begin
                    sel_step = 1'b1;
                    if (sel_at_last) begin
                        if (row_at_last) begin
                            state_next = DONE;
                        end else begin
                            row_step   = 1'b1;
                            state_next = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SCHED_PARAM_CHECK_EN
    // Reject pulse, one cycle after the offending start.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign o_err = err_reg;
`else
    assign o_err = 1'b0;
`endif

    // Status and flags decode only from registered state, never from i_ready.
    assign o_valid    = (state_reg == STREAM);
    assign o_busy     = (state_reg != IDLE);
    assign o_done     = (state_reg == DONE);
    assign o_row_last = o_valid & sel_at_last;
    assign o_last     = o_row_last & row_at_last;

endmodule

// File: tb/tb_reuse_sel_sched.sv
// Directed bench for reuse_sel_sched: full-ready runs, backpressure,
// address wrap, abort, asynchronous reset and start-parameter rejection.
module tb_reuse_sel_sched;

    logic       clk;
    logic       i_rst_n;
    logic       i_start;
    logic [3:0] i_base_addr;
    logic [4:0] i_num_rows;
    logic [7:0] i_num_sel;
    logic       i_abort;
    logic       i_ready;
    logic [3:0] o_ram_addr;
    logic [6:0] o_sel;
    logic       o_valid;
    logic       o_row_last;
    logic       o_last;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int n_cmp = 0;
    int n_bad = 0;

    reuse_sel_sched dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_num_rows  (i_num_rows),
        .i_num_sel   (i_num_sel),
        .i_abort     (i_abort),
        .i_ready     (i_ready),
        .o_ram_addr  (o_ram_addr),
        .o_sel       (o_sel),
        .o_valid     (o_valid),
        .o_row_last  (o_row_last),
        .o_last      (o_last),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, row_last, last, busy, done, err}
    function automatic logic [5:0] flags();
        return {o_valid, o_row_last, o_last, o_busy, o_done, o_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_stream(input string tag, input int addr, input int sel,
                                 input logic rl, input logic l);
        check({tag, "_flags"}, 32'(flags()), 32'({1'b1, rl, l, 1'b1, 1'b0, 1'b0}));
        check({tag, "_sel"}, 32'(o_sel), 32'(sel));
        check({tag, "_addr"}, 32'(o_ram_addr), 32'(addr));
        $display("xfer %s addr=%0d sel=%0d row_last=%0b last=%0b", tag, o_ram_addr, o_sel, o_row_last, o_last);
    endtask

    // Full-ready run; parameters are scrambled right after the start edge.
    task automatic run_full(input int base, input int rows, input int nsel);
        int addr;
        i_base_addr = 4'(base);
        i_num_rows  = 5'(rows);
        i_num_sel   = 8'(nsel);
        i_ready     = 1'b1;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        i_base_addr = ~i_base_addr;
        i_num_rows  = 5'd1;
        i_num_sel   = 8'd1;
        for (int r = 0; r < rows; r++) begin
            addr = (base + r) % 16;
            check("fetch_flags", 32'(flags()), 32'(6'b000100));
            check("fetch_addr", 32'(o_ram_addr), 32'(addr));
            check("fetch_sel", 32'(o_sel), 32'd0);
            tick();
            for (int s = 0; s < nsel; s++) begin
                expect_stream("run", addr, s, (s == nsel - 1), (s == nsel - 1) && (r == rows - 1));
                tick();
            end
        end
        check("done_flags", 32'(flags()), 32'(6'b000110));
        tick();
        check("idle_flags", 32'(flags()), 32'(6'b000000));
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_num_rows  = '0;
        i_num_sel   = '0;
        i_abort     = 1'b0;
        i_ready     = 1'b0;
        tick();
        tick();
        check("rst_flags", 32'(flags()), 32'(6'b000000));
        check("rst_sel", 32'(o_sel), 32'd0);
        check("rst_addr", 32'(o_ram_addr), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Base run: address 3 sel 0..3, bubble, address 4 sel 0..3, done.
        run_full(3, 2, 4);
        // Wrap-around: second row address is 0.
        run_full(15, 2, 3);

        // Backpressure: hold at sel=2 for three cycles.
        i_base_addr = 4'd5;
        i_num_rows  = 5'd1;
        i_num_sel   = 8'd4;
        i_ready     = 1'b1;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        check("bp_fetch", 32'(flags()), 32'(6'b000100));
        tick();
        expect_stream("bp0", 5, 0, 1'b0, 1'b0);
        tick();
        expect_stream("bp1", 5, 1, 1'b0, 1'b0);
        tick();
        expect_stream("bp2", 5, 2, 1'b0, 1'b0);
        i_ready = 1'b0;
        i_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_stream("bp_hold", 5, 2, 1'b0, 1'b0);
        end
        i_ready = 1'b1;
        i_start = 1'b0;
        tick();
        expect_stream("bp3", 5, 3, 1'b1, 1'b1);
        tick();
        check("bp_done", 32'(flags()), 32'(6'b000110));
        tick();
        check("bp_idle", 32'(flags()), 32'(6'b000000));

        // Abort during STREAM with a simultaneous handshake.
        i_base_addr = 4'd2;
        i_num_rows  = 5'd2;
        i_num_sel   = 8'd3;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        expect_stream("ab0", 2, 0, 1'b0, 1'b0);
        tick();
        expect_stream("ab1", 2, 1, 1'b0, 1'b0);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_idle", 32'(flags()), 32'(6'b000000));
        tick();
        check("abort_no_done", 32'(flags()), 32'(6'b000000));
        run_full(0, 1, 2);

        // Asynchronous reset mid-STREAM, between clock edges.
        i_base_addr = 4'd7;
        i_num_rows  = 5'd2;
        i_num_sel   = 8'd5;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        tick();
        expect_stream("ar2", 7, 2, 1'b0, 1'b0);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("arst_flags", 32'(flags()), 32'(6'b000000));
        check("arst_sel", 32'(o_sel), 32'd0);
        check("arst_addr", 32'(o_ram_addr), 32'd0);
        tick();
        check("arst_hold", 32'(flags()), 32'(6'b000000));
        i_rst_n = 1'b1;
        tick();
        run_full(1, 1, 1);

        // Out-of-range select count.
        i_base_addr = 4'd0;
        i_num_rows  = 5'd1;
        i_num_sel   = 8'd82;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
`ifdef SCHED_PARAM_CHECK_EN
        check("reject_err", 32'(flags()), 32'(6'b000001));
        tick();
        check("reject_after", 32'(flags()), 32'(6'b000000));
`else
        check("nocheck_err", 32'(flags()), 32'(6'b000100));
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("nocheck_abort", 32'(flags()), 32'(6'b000000));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
